// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - Branch condition encodings, result layout and compare helper shared with decode
package branch_pkg;

    // Width of the default result view; the resolve unit carries its own XLEN parameter.
    localparam int BR_XLEN = 32;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef struct packed {
        logic               taken;
        logic               illegal;
        logic               mispredict;
        logic [BR_XLEN-1:0] next_pc;
    } br_result_t;

    // funct3 values 010 and 011 are unassigned in the branch opcode space.
    function automatic logic br_is_reserved(input logic [2:0] funct3);
        return (funct3[2:1] == 2'b01);
    endfunction

    // Operands are sign-extended to 64 bits by the caller; sign extension keeps
    // both signed and unsigned ordering, so one compare serves RV32 and RV64.
    function automatic logic br_compare(input logic [2:0]  funct3,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
        logic result;
        result = 1'b0;
        case (funct3)
            BR_BEQ:  result = (a == b);
            BR_BNE:  result = (a != b);
            BR_BLT:  result = ($signed(a) <  $signed(b));
            BR_BGE:  result = ($signed(a) >= $signed(b));
            BR_BLTU: result = (a <  b);
            BR_BGEU: result = (a >= b);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bru_skid_buffer.sv
// rtl/bru_skid_buffer.sv - Generic 2-entry valid/ready skid buffer with flush and registered ready
module bru_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic w_accept;
    logic w_drain;
    logic w_main_free;

    assign w_accept    = i_valid & r_in_ready;
    assign w_drain     = r_main_valid & i_ready;
    assign w_main_free = ~r_main_valid | w_drain;

    // Main/skid occupancy and data; ready is the registered inverse of next skid occupancy,
    // so an accept can never coincide with a full skid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_main_valid <= w_accept;
                r_in_ready   <= 1'b1;
                if (w_accept) begin
                    r_main_data <= i_data;
                end
            end
        end else if (w_accept) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - Branch compare, next-PC and mispredict resolution; BRU_STATS_EN adds counters
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_branch,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);
    import branch_pkg::*;

    // Payload: {branch, taken, illegal, mispredict, next_pc}; branch is kept for the counters.
    localparam int DATA_W = XLEN + 4;

    logic [63:0]       w_a64;
    logic [63:0]       w_b64;
    logic              w_illegal;
    logic              w_taken;
    logic              w_mispredict;
    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_seq_pc;
    logic [XLEN-1:0]   w_next_pc;
    logic [DATA_W-1:0] w_in_data;
    logic [DATA_W-1:0] w_out_data;
    logic              w_out_branch;

    assign w_a64 = 64'($signed(in_a));
    assign w_b64 = 64'($signed(in_b));

    assign w_illegal    = in_branch & br_is_reserved(in_funct3);
    assign w_taken      = in_branch & ~w_illegal & br_compare(in_funct3, w_a64, w_b64);
    assign w_target     = in_pc + in_imm;
    assign w_seq_pc     = in_pc + XLEN'(4);
    assign w_next_pc    = w_taken ? w_target : w_seq_pc;
    assign w_mispredict = in_branch & ~w_illegal & (w_taken ^ in_pred_taken);

    assign w_in_data = {in_branch, w_taken, w_illegal, w_mispredict, w_next_pc};

    bru_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_data),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_data)
    );

    assign w_out_branch   = w_out_data[XLEN+3];
    assign out_taken      = w_out_data[XLEN+2];
    assign out_illegal    = w_out_data[XLEN+1];
    assign out_mispredict = w_out_data[XLEN];
    assign out_next_pc    = w_out_data[XLEN-1:0];

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispredicts;
    logic             w_out_hs;

    // A handshake in a flush cycle still reaches the consumer, so it is counted.
    assign w_out_hs = out_valid & out_ready;

    // Saturating counters of consumed legal branches and mispredictions; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_out_hs && w_out_branch && !out_illegal && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + CNT_W'(1);
            end
            if (w_out_hs && out_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + CNT_W'(1);
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    logic w_unused_branch;
    assign w_unused_branch  = w_out_branch;
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, parametrised branch resolution stage for the execute pipeline. It evaluates the RV32/RV64 conditional-branch comparison (beq/bne/blt/bge/bltu/bgeu), computes the actual next PC and detects misprediction against the fetch-stage prediction. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so the unit sustains one branch per cycle with a fully registered `in_ready`. It sits between the operand-read stage and the fetch redirect/commit logic.

## Interface
- `XLEN`, 32: operand and PC width (32 or 64).
- `CNT_W`, 16: statistics counter width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous pipeline flush; discards all buffered results.
- `in_valid` in 1: input request valid.
- `in_ready` out 1: registered; unit can accept this cycle.
- `in_branch` in 1: instruction is a conditional branch.
- `in_funct3` in 3: branch condition encoding.
- `in_a`, `in_b` in XLEN: rs1/rs2 operands.
- `in_pc` in XLEN: instruction PC.
- `in_imm` in XLEN: sign-extended branch offset.
- `in_pred_taken` in 1: fetch-stage prediction.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_taken` out 1: branch actually taken.
- `out_next_pc` out XLEN: actual next PC.
- `out_mispredict` out 1: prediction was wrong; redirect to `out_next_pc`.
- `out_illegal` out 1: `in_branch` with reserved funct3 (010/011).
- `stat_branches` out CNT_W: resolved-branch count.
- `stat_mispredicts` out CNT_W: misprediction count.

## Operation
- Condition, with `in_branch`=1: 000 `a==b`, 001 `a!=b`, 100 signed `a<b`, 101 signed `a>=b`, 110 unsigned `a<b`, 111 unsigned `a>=b`. For 010/011: taken=0 and illegal=1.
- With `in_branch`=0: taken=0, illegal=0 and mispredict=0. The next PC is `pc+4`.
- Next PC is `pc+imm` if taken, else `pc+4`. Both sums are computed modulo 2^XLEN and wrap silently.
- Mispredict is `in_branch & !illegal & (taken != pred_taken)`. An illegal branch reports mispredict=0, and the trap logic handles it.
- Computation is combinational on the input side. The result word is captured on the input handshake.
- Buffer: a main register drives the outputs, backed by a skid register.
  - Main empty on accept: data goes to main.
  - Main full and not draining on accept: data goes to skid.
  - Main drains while skid is full: skid moves to main.
  - `in_ready` next cycle is `!skid_valid_next`.
- Ordering is strict FIFO. No result is dropped or duplicated.
- `flush`: clears main_valid and skid_valid, and sets `in_ready`=1 next cycle. An input handshake in the same cycle is discarded. `flush` has priority over accept and drain. The output handshake in a flush cycle still completes for the consumer.
- Output data holds stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Latency is 1 cycle: input accepted at edge N gives `out_valid`=1 after edge N.
- Throughput is 1 result per cycle when `out_ready` is held at 1.
- Back-pressure: after 2 accepted, unconsumed results, `in_ready` falls on the next cycle.
- Reset values: `out_valid`=0 and `in_ready`=1. All data outputs are 0. Both counters are 0.
- Reset mid-operation clears all entries, with the same effect as `flush`, and also zeroes the counters.

## Configuration
- `BRU_STATS_EN` defined:
  - `stat_branches` increments on each output handshake with branch=1 and illegal=0.
  - `stat_mispredicts` increments on each output handshake with mispredict=1.
  - Both counters saturate at 2^CNT_W-1.
  - `flush` does not clear them; only `rst` does.
- Not defined: both stat ports are tied to 0 and no counter flops are built.

## Structure
- Package `branch_pkg`:
  - funct3 constants `BR_BEQ`..`BR_BGEU`.
  - `br_result_t` packed struct {taken, illegal, mispredict, next_pc}, parametrised via `XLEN` localparam.
  - Compare function shared with the decode stage.
- Sub-module `bru_skid_buffer` holds the generic 2-entry valid/ready skid of a `DATA_W` payload, including flush. The top level holds the compare, adders and counters.

## Test plan
1. Directed compare:
   - a=5, b=5, funct3=000, pc=0x100, imm=0x20, pred=0 -> taken=1, next_pc=0x120, mispredict=1, one cycle later.
   - a=0xFFFFFFFF, b=1, funct3=100 -> taken=1 (signed). funct3=110 -> taken=0.
2. Reserved funct3=010 with branch=1 -> illegal=1, taken=0, mispredict=0, next_pc=pc+4.
3. Wrap: pc=0xFFFFFFFC, not taken -> next_pc=0x0.
4. Back-pressure:
   - 4 back-to-back inputs with `out_ready`=0 -> `in_ready` drops after 2 accepts.
   - Raise `out_ready` -> the 4 results emerge in order, one per cycle, with no loss.
5. Flush with both entries full and `in_valid`=1 -> `out_valid`=0 next cycle, `in_ready`=1, and the flush-cycle input is not emitted.
6. `BRU_STATS_EN` with CNT_W=2: 5 mispredicting branches consumed -> `stat_branches`=3 and `stat_mispredicts`=3 (saturated). `rst` returns both to 0.
